// File: rtl/rv32_mem_arbiter_if.sv
// rv32_mem_arbiter_if: fetch, load/store and SRAM buses shared by the priRV32 memory arbiter
interface rv32_mem_arbiter_if #(
    parameter int MEM_AW = 12
);
    logic              i_req, i_gnt, i_rvalid;
    logic [31:0]       i_addr, i_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]        d_be;
    logic [31:0]       d_addr, d_wdata, d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: single-port SRAM arbiter, data priority with bounded fetch starvation
// Optional memory-mapped LED register enabled by MEM_ARB_LED_MMIO_EN.
module rv32_mem_arbiter #(
    parameter int          MEM_AW     = 12,
    parameter int          STREAK_MAX = 4,
    parameter logic [31:0] LED_ADDR   = 32'h1000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    rv32_mem_arbiter_if.slave bus,
    output logic              led
);
    typedef enum logic [2:0] {IDLE, RSP_I, RSP_D_RD, RSP_D_WR, RSP_LED} rsp_t;
    rsp_t       rsp, rsp_nx;
    logic [3:0] streak, streak_nx;
    logic       i_win, gi, gd, d_led, unused_bits;
`ifdef MEM_ARB_LED_MMIO_EN
    assign d_led = bus.d_addr == LED_ADDR;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) led <= 1'b0;
        else if (gd && d_led && bus.d_we && bus.d_be[0]) led <= bus.d_wdata[0];
`else
    assign d_led = 1'b0;
    assign led   = 1'b0;
`endif
    // Address bits outside the word index are deliberately ignored (SRAM aliases).
    assign unused_bits = ^{bus.i_addr[31:MEM_AW+2], bus.i_addr[1:0],
                           bus.d_addr[31:MEM_AW+2], bus.d_addr[1:0], LED_ADDR};
    always_comb begin
        i_win         = bus.i_req && (!bus.d_req || streak == 4'(STREAK_MAX));
        gi            = rst_n && i_win;
        gd            = rst_n && bus.d_req && !i_win;
        bus.i_gnt     = gi;
        bus.d_gnt     = gd;
        bus.mem_en    = gi || (gd && !d_led);
        bus.mem_we    = (gd && !d_led && bus.d_we) ? bus.d_be : 4'b0;
        bus.mem_addr  = gd ? bus.d_addr[MEM_AW+1:2] : gi ? bus.i_addr[MEM_AW+1:2] : '0;
        bus.mem_wdata = (gd && bus.d_we) ? bus.d_wdata : 32'b0;
        streak_nx     = (!bus.i_req || gi) ? 4'b0 :
                        (gd && streak != 4'(STREAK_MAX)) ? streak + 4'd1 : streak;
        rsp_nx        = gi ? RSP_I : !gd ? IDLE : d_led ? RSP_LED : bus.d_we ? RSP_D_WR : RSP_D_RD;
        bus.i_rvalid  = rsp == RSP_I;
        bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : 32'b0;
        bus.d_rvalid  = rsp inside {RSP_D_RD, RSP_D_WR, RSP_LED};
        bus.d_rdata   = rsp == RSP_D_RD ? bus.mem_rdata : rsp == RSP_LED ? {31'b0, led} : 32'b0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rsp    <= IDLE;
            streak <= 4'b0;
        end else begin
            rsp    <= rsp_nx;
            streak <= streak_nx;
        end
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: table-driven vectors with a response scoreboard for rv32_mem_arbiter
module tb_rv32_mem_arbiter;
    localparam int          AW    = 12;
    localparam logic [31:0] LED_A = 32'h1000_0000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic led;
    rv32_mem_arbiter_if #(.MEM_AW(AW)) bus ();
    rv32_mem_arbiter #(.MEM_AW(AW), .STREAK_MAX(4), .LED_ADDR(LED_A)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .led(led)
    );
    always #5 clk = ~clk;
    logic [31:0] sram [0:(1<<AW)-1];
    always @(posedge clk)
        if (bus.mem_en) begin
            bus.mem_rdata <= sram[bus.mem_addr];
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    typedef struct {
        logic ir; logic [31:0] ia;
        logic dr; logic dw; logic [3:0] be; logic [31:0] da; logic [31:0] dwd;
        logic ei; logic ed; logic een; logic [3:0] ewe; logic [AW-1:0] ea;
    } vec_t;
    typedef struct { logic iv; logic [31:0] id; logic dv; logic [31:0] dd; } exp_t;
    vec_t        vt[$];
    exp_t        q[$];
    logic [31:0] shadow [0:(1<<AW)-1];
    logic        exp_led = 1'b0;
    logic        ig_seen = 1'b0;
    int          n_chk = 0, n_fail = 0, wait_n = 0, max_wait = 0;
    vec_t        v;

    function automatic vec_t nop();
        return '{default: '0};
    endfunction
    function automatic vec_t fet(input logic [31:0] a, input logic [AW-1:0] ea);
        return '{1'b1, a, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'h0, ea};
    endfunction
    function automatic vec_t ld(input logic [31:0] a, input logic [AW-1:0] ea);
        return '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, a, 32'h0, 1'b0, 1'b1, 1'b1, 4'h0, ea};
    endfunction
    function automatic vec_t st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                                input logic [AW-1:0] ea);
        return '{1'b0, 32'h0, 1'b1, 1'b1, be, a, wd, 1'b0, 1'b1, 1'b1, be, ea};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic check_rsp();
        exp_t r;
        r = '{1'b0, 32'h0, 1'b0, 32'h0};
        if (q.size() > 0) r = q.pop_front();
        chk("i_rvalid", 32'(bus.i_rvalid), 32'(r.iv));
        chk("i_rdata", bus.i_rdata, r.id);
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(r.dv));
        chk("d_rdata", bus.d_rdata, r.dd);
        chk("led", 32'(led), 32'(exp_led));
    endtask

    task automatic chk_zero();
        chk("rst_gnt", 32'({bus.i_gnt, bus.d_gnt}), 32'h0);
        chk("rst_rvalid", 32'({bus.i_rvalid, bus.d_rvalid}), 32'h0);
        chk("rst_i_rdata", bus.i_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_led", 32'(led), 32'h0);
    endtask

    task automatic run(input vec_t x);
        exp_t r;
        logic lw;
        bus.i_req = x.ir; bus.i_addr = x.ia;
        bus.d_req = x.dr; bus.d_we = x.dw; bus.d_be = x.be; bus.d_addr = x.da; bus.d_wdata = x.dwd;
        @(negedge clk);
        check_rsp();
        chk("i_gnt", 32'(bus.i_gnt), 32'(x.ei));
        chk("d_gnt", 32'(bus.d_gnt), 32'(x.ed));
        chk("mem_en", 32'(bus.mem_en), 32'(x.een));
        chk("mem_we", 32'(bus.mem_we), 32'(x.ewe));
        if (x.een) chk("mem_addr", 32'(bus.mem_addr), 32'(x.ea));
        if (x.een && x.ed && x.dw) chk("mem_wdata", bus.mem_wdata, x.dwd);
        lw = 1'b0;
`ifdef MEM_ARB_LED_MMIO_EN
        lw = x.da == LED_A;
`endif
        r = '{1'b0, 32'h0, 1'b0, 32'h0};
        if (x.ei) r = '{1'b1, shadow[x.ea], 1'b0, 32'h0};
        else if (x.ed) begin
            if (lw && x.dw && x.be[0]) exp_led = x.dwd[0];
            r = '{1'b0, 32'h0, 1'b1, lw ? {31'b0, exp_led} : x.dw ? 32'h0 : shadow[x.ea]};
            if (!lw && x.dw)
                for (int b = 0; b < 4; b++)
                    if (x.be[b]) shadow[x.ea][8*b +: 8] = x.dwd[8*b +: 8];
        end
        if (x.ei || x.ed) q.push_back(r);
        ig_seen = bus.i_gnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h20; bus.d_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vt = '{st(32'h10, 4'hF, 32'hDEAD_BEEF, 12'd4), st(32'h20, 4'hF, 32'hFFFF_FFFF, 12'd8),
               st(32'h0, 4'hF, 32'h1111_11A0, 12'd0), st(32'h4, 4'hF, 32'h2222_22A1, 12'd1),
               st(32'h8, 4'hF, 32'h3333_33A2, 12'd2), nop(),
               fet(32'h10, 12'd4), nop(),
               st(32'h20, 4'b0011, 32'h1234_5678, 12'd8), ld(32'h20, 12'd8), nop(),
               ld(32'h0, 12'd0), ld(32'h4, 12'd1), ld(32'h8, 12'd2), nop(),
               ld(32'h0000_4010, 12'd4), fet(32'h13, 12'd4), ld(32'h8000_0008, 12'd2), nop()};
        foreach (vt[k]) run(vt[k]);
        chk("shadow_partial_store", shadow[8], 32'hFFFF_5678);
        // Both ports saturated: four data grants, then the fetch gets through.
        for (int k = 0; k < 20; k++) begin
            v = '{1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0,
                  k % 5 == 4, k % 5 != 4, 1'b1, 4'h0, (k % 5 == 4) ? 12'd4 : 12'd0};
            run(v);
            wait_n = ig_seen ? 0 : wait_n + 1;
            if (wait_n > max_wait) max_wait = wait_n;
        end
        chk("max_fetch_wait", 32'(max_wait), 32'd4);
        run(nop());
        run(ld(32'h4, 12'd1));
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero();
        q.delete();
        exp_led = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(ld(32'h8, 12'd2));
        run(nop());
`ifdef MEM_ARB_LED_MMIO_EN
        run('{1'b0, 32'h0, 1'b1, 1'b1, 4'b0001, LED_A, 32'h1, 1'b0, 1'b1, 1'b0, 4'h0, 12'd0});
        run('{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, LED_A, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 12'd0});
        run(nop());
        chk("led_mmio", 32'(led), 32'h1);
`else
        run(st(LED_A, 4'b0001, 32'h1, 12'd0));
        run(ld(LED_A, 12'd0));
        run(nop());
        chk("led_tied", 32'(led), 32'h0);
        chk("sram_word0", sram[0], 32'h1111_1101);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
